// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with word-by-word line fill.
// Optional hit/miss counters are enabled by defining ICACHE_STAT_EN.
module inst_cache #(
    parameter int INDEX_BITS       = 6,
    parameter int OFFSET_WORDS_LOG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc_from_if,
    output logic        inst_get_ready,
    output logic [31:0] inst_from_ic,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
`ifdef ICACHE_STAT_EN
    input  logic [31:0] mem_resp_data,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`else
    input  logic [31:0] mem_resp_data
`endif
);

    localparam int TAG_BITS  = 32 - INDEX_BITS - OFFSET_WORDS_LOG - 2;
    localparam int LINE_BITS = TAG_BITS + INDEX_BITS;
    localparam int LINES     = 1 << INDEX_BITS;
    localparam int WORDS     = 1 << OFFSET_WORDS_LOG;
    localparam int OFF_LSB   = 2;
    localparam int IDX_LSB   = OFFSET_WORDS_LOG + 2;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t                        state_q, state_d;
    logic [LINES-1:0]              valid_q, valid_d;
    logic [LINE_BITS-1:0]          fill_line_q, fill_line_d;
    logic [OFFSET_WORDS_LOG-1:0]   cnt_q, cnt_d;
    logic                          req_valid_q, req_valid_d;
    logic [31:0]                   req_addr_q, req_addr_d;

    logic [TAG_BITS-1:0]           tag_arr [LINES];
    logic [31:0]                   data_arr [LINES][WORDS];

    logic [TAG_BITS-1:0]           pc_tag;
    logic [INDEX_BITS-1:0]         pc_idx;
    logic [OFFSET_WORDS_LOG-1:0]   pc_off;
    logic [LINE_BITS-1:0]          pc_line;
    logic [INDEX_BITS-1:0]         fill_idx;
    logic [TAG_BITS-1:0]           fill_tag;
    logic                          hit;
    logic                          data_we;
    logic                          tag_we;
    logic                          miss_start;
    logic                          unused_pc_bits;

    assign pc_tag   = pc_from_if[31:32-TAG_BITS];
    assign pc_idx   = pc_from_if[IDX_LSB+INDEX_BITS-1:IDX_LSB];
    assign pc_off   = pc_from_if[IDX_LSB-1:OFF_LSB];
    assign pc_line  = pc_from_if[31:IDX_LSB];
    assign fill_idx = fill_line_q[INDEX_BITS-1:0];
    assign fill_tag = fill_line_q[LINE_BITS-1:INDEX_BITS];

    assign unused_pc_bits = ^pc_from_if[1:0];

    assign hit = (state_q == IDLE) && valid_q[pc_idx]
                 && (tag_arr[pc_idx] == pc_tag);

    assign inst_get_ready = hit;
    assign inst_from_ic   = data_arr[pc_idx][pc_off];
    assign mem_req_valid  = req_valid_q;
    assign mem_req_addr   = req_addr_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        fill_line_d = fill_line_q;
        cnt_d       = cnt_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        data_we     = 1'b0;
        tag_we      = 1'b0;
        miss_start  = 1'b0;
        if (rdy) begin
            unique case (state_q)
                IDLE: begin
                    if (!hit) begin
                        // Drop the old line first so a partial refill never hits.
                        miss_start      = 1'b1;
                        state_d         = FILL;
                        valid_d[pc_idx] = 1'b0;
                        fill_line_d     = pc_line;
                        cnt_d           = '0;
                        req_valid_d     = 1'b1;
                        req_addr_d      = {pc_line, {IDX_LSB{1'b0}}};
                    end
                end
                FILL: begin
                    if (mem_resp_valid) begin
                        data_we    = 1'b1;
                        cnt_d      = cnt_q + 1'b1;
                        req_addr_d = req_addr_q + 32'd4;
                        if (cnt_q == {OFFSET_WORDS_LOG{1'b1}}) begin
                            tag_we            = 1'b1;
                            valid_d[fill_idx] = 1'b1;
                            req_valid_d       = 1'b0;
                            state_d           = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            fill_line_q <= '0;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            fill_line_q <= fill_line_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_arr[fill_idx][cnt_q] <= mem_resp_data;
        end
        if (tag_we) begin
            tag_arr[fill_idx] <= fill_tag;
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (rdy && hit) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (miss_start) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic unused_miss_start;
    assign unused_miss_start = miss_start;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed testbench for inst_cache with a one-cycle-latency memory model.
// Works in both the default and ICACHE_STAT_EN builds.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic [31:0] pc  = 32'h0;
    logic        inst_get_ready;
    logic [31:0] inst_from_ic;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    logic        auto_en = 1'b1;
    logic        auto_v  = 1'b0;
    logic [31:0] auto_d  = 32'h0;
    logic        man_v   = 1'b0;
    logic [31:0] man_d   = 32'h0;
    logic [31:0] req_log [$];

    int n_run  = 0;
    int n_fail = 0;

    assign mem_resp_valid = auto_en ? auto_v : man_v;
    assign mem_resp_data  = auto_en ? auto_d : man_d;

    inst_cache dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .pc_from_if     (pc),
        .inst_get_ready (inst_get_ready),
        .inst_from_ic   (inst_from_ic),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
`ifdef ICACHE_STAT_EN
        .mem_resp_data  (mem_resp_data),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
`else
        .mem_resp_data  (mem_resp_data)
`endif
    );

    always #5 clk = ~clk;

    // Memory answers one cycle after it sees a request, then idles a cycle.
    always @(negedge clk) begin
        if (!auto_en || !rst) begin
            auto_v = 1'b0;
        end else if (mem_req_valid && !auto_v) begin
            auto_v = 1'b1;
            auto_d = mem_req_addr + 32'h100;
            req_log.push_back(mem_req_addr);
        end else begin
            auto_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hit(input string name, output int ticks);
        ticks = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            #1;
            if (inst_get_ready) begin
                ticks = i;
                break;
            end
        end
        n_run++;
        if (ticks == 0) begin
            n_fail++;
            $display("FAIL %s_timeout got no hit within 40 cycles want hit", name);
        end
    endtask

    task automatic test_reset();
        #2;
        n_run++;
        if (inst_get_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hit got %b want 0", inst_get_ready);
        end
        n_run++;
        if (mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req_valid got %b want 0", mem_req_valid);
        end
        n_run++;
        if (mem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_req_addr got %h want 0", mem_req_addr);
        end
`ifdef ICACHE_STAT_EN
        n_run++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_stats got %h/%h want 0/0", hit_cnt, miss_cnt);
        end
`endif
        tick();
        tick();
    endtask

    task automatic test_cold_fill();
        int t;
        pc = 32'h0;
        req_log.delete();
        tick();
        rst = 1'b1;
        wait_hit("cold", t);
        n_run++;
        if (t !== 8) begin
            n_fail++;
            $display("FAIL cold_latency got %0d want 8", t);
        end
        n_run++;
        if (req_log.size() !== 4) begin
            n_fail++;
            $display("FAIL cold_req_count got %0d want 4", req_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_run++;
                if (req_log[i] !== 32'(i * 4)) begin
                    n_fail++;
                    $display("FAIL cold_req_addr%0d got %h want %h",
                             i, req_log[i], 32'(i * 4));
                end
            end
        end
        n_run++;
        if (inst_from_ic !== 32'h100) begin
            n_fail++;
            $display("FAIL cold_data got %h want 00000100", inst_from_ic);
        end
    endtask

    task automatic test_warm();
        logic [31:0] exp;
        for (int i = 1; i < 4; i++) begin
            pc = 32'(i * 4);
            exp = 32'h100 + 32'(i * 4);
            #1;
            n_run++;
            if (inst_get_ready !== 1'b1 || inst_from_ic !== exp) begin
                n_fail++;
                $display("FAIL warm_hit%0d got %b/%h want 1/%h",
                         i, inst_get_ready, inst_from_ic, exp);
            end
            tick();
            n_run++;
            if (mem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL warm_req_valid%0d got %b want 0", i, mem_req_valid);
            end
        end
    endtask

    task automatic test_conflict();
        int t;
        pc = 32'h400;
        req_log.delete();
        #1;
        n_run++;
        if (inst_get_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_miss got %b want 0", inst_get_ready);
        end
        wait_hit("conflict_fill", t);
        n_run++;
        if (req_log.size() !== 4 || req_log[0] !== 32'h400
            || req_log[3] !== 32'h40c) begin
            n_fail++;
            $display("FAIL conflict_reqs got n=%0d first=%h want n=4 first=00000400",
                     req_log.size(), req_log[0]);
        end
        n_run++;
        if (inst_from_ic !== 32'h500) begin
            n_fail++;
            $display("FAIL conflict_data got %h want 00000500", inst_from_ic);
        end
        pc = 32'h0;
        req_log.delete();
        #1;
        n_run++;
        if (inst_get_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_evict got %b want 0", inst_get_ready);
        end
        wait_hit("conflict_refill", t);
        n_run++;
        if (inst_from_ic !== 32'h100 || req_log[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL conflict_refill got %h first=%h want 00000100 first=0",
                     inst_from_ic, req_log[0]);
        end
    endtask

    task automatic test_redirect();
        int  t;
        bit  seen_low;
        bit  ok;
        pc = 32'h40;
        req_log.delete();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_log.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        pc = 32'h80;
        seen_low = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (!mem_req_valid) seen_low = 1'b1;
                if (seen_low && mem_req_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL redirect_timeout got no new request want request");
        end
        n_run++;
        if (mem_req_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL redirect_new_addr got %h want 00000080", mem_req_addr);
        end
        for (int i = 0; i < 4; i++) begin
            n_run++;
            if (req_log.size() < 4 || req_log[i] !== 32'h40 + 32'(i * 4)) begin
                n_fail++;
                $display("FAIL redirect_old_addr%0d got %h want %h",
                         i, req_log[i], 32'h40 + 32'(i * 4));
            end
        end
        wait_hit("redirect_fill", t);
        n_run++;
        if (inst_from_ic !== 32'h180) begin
            n_fail++;
            $display("FAIL redirect_data got %h want 00000180", inst_from_ic);
        end
        pc = 32'h40;
        #1;
        n_run++;
        if (inst_get_ready !== 1'b1 || inst_from_ic !== 32'h140) begin
            n_fail++;
            $display("FAIL redirect_old_line got %b/%h want 1/00000140",
                     inst_get_ready, inst_from_ic);
        end
    endtask

    task automatic test_rdy_stall();
        auto_en = 1'b0;
        man_v   = 1'b0;
        pc      = 32'h100;
        tick();
        n_run++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL stall_start got %b/%h want 1/00000100",
                     mem_req_valid, mem_req_addr);
        end
        man_v = 1'b1;
        man_d = 32'h200;
        tick();
        man_v = 1'b0;
        rdy   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            man_v = 1'b1;
            man_d = 32'hdead_beef;
            tick();
            n_run++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h104) begin
                n_fail++;
                $display("FAIL stall_frozen%0d got %b/%h want 1/00000104",
                         i, mem_req_valid, mem_req_addr);
            end
        end
        man_v = 1'b0;
        rdy   = 1'b1;
        for (int w = 1; w < 4; w++) begin
            man_v = 1'b1;
            man_d = 32'h200 + 32'(w * 4);
            tick();
            man_v = 1'b0;
            tick();
        end
        #1;
        n_run++;
        if (inst_get_ready !== 1'b1 || inst_from_ic !== 32'h200) begin
            n_fail++;
            $display("FAIL stall_word0 got %b/%h want 1/00000200",
                     inst_get_ready, inst_from_ic);
        end
        pc = 32'h104;
        #1;
        n_run++;
        if (inst_get_ready !== 1'b1 || inst_from_ic !== 32'h204) begin
            n_fail++;
            $display("FAIL stall_word1 got %b/%h want 1/00000204",
                     inst_get_ready, inst_from_ic);
        end
        auto_en = 1'b1;
    endtask

    task automatic test_reset_midfill();
        int t;
        pc = 32'h40;
        #1;
        n_run++;
        if (inst_get_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_prehit got %b want 1", inst_get_ready);
        end
        pc = 32'hc0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_run++;
        if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_async got %b/%h want 0/0", mem_req_valid, mem_req_addr);
        end
`ifdef ICACHE_STAT_EN
        n_run++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_stats got %h/%h want 0/0", hit_cnt, miss_cnt);
        end
`endif
        tick();
        rst = 1'b1;
        pc  = 32'h40;
        #1;
        n_run++;
        if (inst_get_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_invalid got %b want 0", inst_get_ready);
        end
        tick();
        n_run++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL rst_refetch got %b/%h want 1/00000040",
                     mem_req_valid, mem_req_addr);
        end
`ifdef ICACHE_STAT_EN
        n_run++;
        if (miss_cnt !== 32'h1) begin
            n_fail++;
            $display("FAIL rst_miss_cnt got %h want 1", miss_cnt);
        end
`endif
        wait_hit("rst_refill", t);
        n_run++;
        if (inst_from_ic !== 32'h140) begin
            n_fail++;
            $display("FAIL rst_refill_data got %h want 00000140", inst_from_ic);
        end
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_warm();
        test_conflict();
        test_redirect();
        test_rdy_stall();
        test_reset_midfill();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
